// File: rtl/bpu_pkg.sv
// Shared decode constants and helpers for the gshare branch predictor:
// RV32 control-flow opcodes, link-register test, immediates, counter arithmetic.
package bpu_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JAL    = 2'd2,
        CF_JALR   = 2'd3
    } cf_kind_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Counters are carried at 4 bits here; callers keep the low w bits.
    function automatic logic [3:0] ctr_init(input int unsigned w);
        logic [4:0] v;
        v = (5'd1 << (w - 32'd1)) - 5'd1;
        return v[3:0];
    endfunction

    function automatic logic [3:0] ctr_next(input logic [3:0] ctr, input logic taken,
                                            input int unsigned w);
        logic [4:0] max_v;
        logic [3:0] res;
        max_v = (5'd1 << w) - 5'd1;
        if (taken) begin
            if ({1'b0, ctr} == max_v) res = ctr;
            else                      res = ctr + 4'd1;
        end else begin
            if (ctr == 4'd0) res = ctr;
            else             res = ctr - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gshare_bpu_if.sv
// Fetch-side prediction and EXU-side resolution signals of the gshare predictor.
// master = fetch/EXU pipeline, slave = predictor.
interface gshare_bpu_if #(
    parameter int GHR_W = 8
);
    logic [31:0]      inst_i;
    logic             inst_valid_i;
    logic [31:0]      pc_i;
    logic             any_stall_i;
    logic             branch_taken_o;
    logic [31:0]      branch_addr_o;
    logic             is_pred_branch_o;
    logic [GHR_W-1:0] pred_ghr_o;
    logic             update_valid_i;
    logic [31:0]      update_pc_i;
    logic [GHR_W-1:0] update_ghr_i;
    logic             real_taken_i;
    logic             mispredict_i;

    modport master (
        output inst_i, inst_valid_i, pc_i, any_stall_i,
        output update_valid_i, update_pc_i, update_ghr_i, real_taken_i, mispredict_i,
        input  branch_taken_o, branch_addr_o, is_pred_branch_o, pred_ghr_o
    );

    modport slave (
        input  inst_i, inst_valid_i, pc_i, any_stall_i,
        input  update_valid_i, update_pc_i, update_ghr_i, real_taken_i, mispredict_i,
        output branch_taken_o, branch_addr_o, is_pred_branch_o, pred_ghr_o
    );
endinterface

// File: rtl/bpu_ras.sv
// Circular return address stack: pushing when full overwrites the oldest link,
// count saturates at DEPTH so the stack never underflows into stale slots.
module bpu_ras #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ptr_q addresses the next free slot; top is the slot just below it.
    assign top_o   = mem_q[ptr_q - PTR_W'(1)];
    assign empty_o = (cnt_q == {CNT_W{1'b0}});

    // Next pointer/count; push wins over pop.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_W'(DEPTH)) cnt_d = cnt_q;
            else                        cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_i) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Link storage; contents are don't-care while the stack is empty.
    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/gshare_bpu.sv
// gshare branch predictor with RAS: same-cycle prediction for fetch,
// speculative GHR/RAS commit on fire, PHT training and GHR repair from EXU.
module gshare_bpu
    import bpu_pkg::*;
#(
    parameter int PHT_ENTRIES = 1024,
    parameter int GHR_W       = 8,
    parameter int CTR_W       = 2,
    parameter int RAS_DEPTH   = 8
) (
    input logic         clk,
    input logic         rst,
    gshare_bpu_if.slave bpu
);
    localparam int             PHT_IDX_W  = $clog2(PHT_ENTRIES);
    localparam logic [3:0]     CTR_INIT_W = ctr_init(CTR_W);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_INIT_W[CTR_W-1:0];

    logic [CTR_W-1:0]     pht_q [PHT_ENTRIES];
    logic [GHR_W-1:0]     ghr_q, ghr_d;

    cf_kind_e             kind_s;
    logic                 is_branch_s, is_call_s, is_ret_s;
    logic [PHT_IDX_W-1:0] ridx_s, widx_s;
    logic                 pred_dir_s, pred_s, fire_s;
    logic [31:0]          seq_pc_s, target_s;
    logic [3:0]           ctr_upd_s;
    logic                 ras_push_s, ras_pop_s, ras_empty_s;
    logic [31:0]          ras_top_s;
    logic                 unused_s;

    // Opcode class of the fetched instruction.
    always_comb begin
        case (bpu.inst_i[6:0])
            OPC_BRANCH: kind_s = CF_BRANCH;
            OPC_JAL:    kind_s = CF_JAL;
            OPC_JALR:   kind_s = CF_JALR;
            default:    kind_s = CF_NONE;
        endcase
    end

    assign is_branch_s = (kind_s == CF_BRANCH);
    assign is_call_s   = ((kind_s == CF_JAL) || (kind_s == CF_JALR)) && is_link(bpu.inst_i[11:7]);
    assign is_ret_s    = (kind_s == CF_JALR) && is_link(bpu.inst_i[19:15])
                         && !is_link(bpu.inst_i[11:7]);

    assign ridx_s     = bpu.pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
    assign pred_dir_s = pht_q[ridx_s][CTR_W-1];
    assign seq_pc_s   = bpu.pc_i + 32'd4;
    assign fire_s     = bpu.inst_valid_i & ~bpu.any_stall_i & ~bpu.mispredict_i;

    // Raw direction and target before fetch-side gating.
    always_comb begin
        if (is_branch_s) begin
            pred_s   = pred_dir_s;
            target_s = bpu.pc_i + imm_b(bpu.inst_i);
        end else if (kind_s == CF_JAL) begin
            pred_s   = 1'b1;
            target_s = bpu.pc_i + imm_j(bpu.inst_i);
        end else if (is_ret_s && !ras_empty_s) begin
            pred_s   = 1'b1;
            target_s = ras_top_s;
        end else begin
            pred_s   = 1'b0;
            target_s = seq_pc_s;
        end
    end

    assign bpu.branch_taken_o   = pred_s & fire_s;
    assign bpu.branch_addr_o    = pred_s ? target_s : seq_pc_s;
    assign bpu.is_pred_branch_o = pred_s & fire_s & is_branch_s;
    assign bpu.pred_ghr_o       = ghr_q;

    // GHR next state: EXU repair beats speculative shift.
    always_comb begin
        if (bpu.mispredict_i) begin
            if (bpu.update_valid_i) ghr_d = {bpu.update_ghr_i[GHR_W-2:0], bpu.real_taken_i};
            else                    ghr_d = bpu.update_ghr_i;
        end else if (fire_s && is_branch_s) begin
            ghr_d = {ghr_q[GHR_W-2:0], pred_dir_s};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Global history register.
    always_ff @(posedge clk) begin
        if (rst) ghr_q <= {GHR_W{1'b0}};
        else     ghr_q <= ghr_d;
    end

    assign widx_s    = bpu.update_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bpu.update_ghr_i);
    assign ctr_upd_s = ctr_next(4'(pht_q[widx_s]), bpu.real_taken_i, CTR_W);

    // Pattern history table; the read port sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else if (bpu.update_valid_i) begin
            pht_q[widx_s] <= ctr_upd_s[CTR_W-1:0];
        end
    end

    assign ras_push_s = fire_s & is_call_s;
    assign ras_pop_s  = fire_s & is_ret_s & ~is_call_s & ~ras_empty_s;

    bpu_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst        (rst),
        .push_i     (ras_push_s),
        .pop_i      (ras_pop_s),
        .push_data_i(seq_pc_s),
        .top_o      (ras_top_s),
        .empty_o    (ras_empty_s)
    );

    assign unused_s = ^{bpu.update_pc_i[31:PHT_IDX_W+2], bpu.update_pc_i[1:0], ctr_upd_s};

endmodule

// File: doc/gshare_bpu.md
Name: gshare_bpu

Overview:
- Next-generation IF-stage branch predictor.
- Generalises the bimodal 2-bit BHT to a gshare PHT: n-bit saturating counters, indexed by the PC XOR a speculative global history register (GHR).
- Adds a return address stack (RAS) that predicts JALR returns and records calls.
- Sits beside the fetch unit. Predicts combinationally in the same cycle. Speculative GHR/RAS state commits at the clock edge. EXU writes back resolved branches and restores the GHR on mispredict.

Parameters:
- PHT_ENTRIES, 1024, counter count; power of 2
- GHR_W, 8, global history bits; must be <= PHT_IDX_W
- CTR_W, 2, counter width; 2..4
- RAS_DEPTH, 8, return stack entries; power of 2
- PHT_IDX_W, localparam = $clog2(PHT_ENTRIES)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_i  in  32  fetched instruction
- inst_valid_i  in  1  instruction valid
- pc_i  in  32  PC of inst_i
- any_stall_i  in  1  pipeline stall
- branch_taken_o  out  1  redirect fetch
- branch_addr_o  out  32  predicted target
- is_pred_branch_o  out  1  conditional branch predicted taken
- pred_ghr_o  out  GHR_W  GHR used for this prediction; carried down the pipe
- update_valid_i  in  1  resolved conditional branch
- update_pc_i  in  32  its PC
- update_ghr_i  in  GHR_W  its pred_ghr snapshot
- real_taken_i  in  1  actual outcome
- mispredict_i  in  1  flush; restore GHR

Behaviour:
- Reset and clocking
  - Single clock domain. Reset is synchronous, active-high, sampled at posedge clk.
  - On reset: every counter = 2^(CTR_W-1)-1 (weakly not-taken); GHR = 0; RAS top pointer = 0; RAS count = 0.
  - Outputs are combinational. With inst_valid_i=0 after reset: branch_taken_o=0, is_pred_branch_o=0, pred_ghr_o=0.
- Decode
  - BRANCH: opcode 1100011.
  - JAL: opcode 1101111.
  - JALR: opcode 1100111.
  - link(r) is true for r = x1 or x5.
  - call = (JAL or JALR) and link(rd).
  - ret = JALR and link(rs1) and not link(rd).
- Prediction (combinational, zero latency)
  - Read index ridx = pc_i[PHT_IDX_W+1:2] XOR zero-extended GHR.
  - BRANCH: taken iff counter MSB = 1; target = pc_i + imm_b.
  - JAL: always taken; target = pc_i + imm_j.
  - ret with RAS count > 0: taken; target = RAS top.
  - ret with empty RAS: not taken.
  - Other JALR: not taken.
  - When not taken, branch_addr_o = pc_i + 4.
  - branch_taken_o = pred & inst_valid_i & ~any_stall_i & ~mispredict_i.
  - is_pred_branch_o = branch_taken_o & BRANCH.
  - pred_ghr_o = current GHR.
- Speculative commit at posedge, when fire = inst_valid_i & ~any_stall_i & ~mispredict_i
  - BRANCH: GHR <= {GHR[GHR_W-2:0], predicted bit}.
  - call: push pc_i + 4. Pointer wraps. When full, overwrite the oldest entry; count saturates at RAS_DEPTH.
  - ret with count > 0: pop, count decrements.
  - call and ret on the same instruction: push only.
- Mispredict
  - mispredict_i=1 has priority over fire.
  - GHR <= {update_ghr_i[GHR_W-2:0], real_taken_i} if update_valid_i; otherwise GHR <= update_ghr_i.
  - RAS is not repaired. This is a known limitation.
- PHT update at posedge when update_valid_i
  - widx = update_pc_i[PHT_IDX_W+1:2] XOR update_ghr_i.
  - Counter +1 on taken, -1 on not-taken, saturating at 0 and 2^CTR_W-1.
  - Read and write to the same index in one cycle: read returns the old value.
  - update_valid_i is independent of stall.
- Reset mid-operation: reset overrides all updates in that cycle.

Decomposition:
- Package bpu_pkg holds:
  - opcode localparams
  - function is_link(reg)
  - imm_b / imm_j extract functions
  - function ctr_next(ctr, taken)
  - function ctr_init
- Sub-module bpu_ras holds the RAS storage and logic.
  - Parameter: DEPTH.
  - Ports: push, pop, push_data, top, empty.
  - Same reset as the top level.

Test Plan:
- Reset, then BRANCH with imm=+16 at pc=0x100 -> branch_taken_o=0, branch_addr_o=0x104, pred_ghr_o=0.
- Three updates taken at pc=0x100 with update_ghr=0, then GHR forced back to 0 via mispredict -> prediction taken, addr=0x110; fourth update leaves counter at 3 (saturates).
- JAL x1 at pc=0x200 fires -> taken to pc+imm_j, RAS top=0x204. Then JALR x0,0(x1) at pc=0x300 -> taken, addr=0x204, RAS empty. Second ret -> not taken, addr=0x304.
- RAS_DEPTH+1 = 9 calls, then 9 rets -> first 8 rets return the 8 newest links in LIFO order; 9th ret is not taken.
- BRANCH predicted taken with any_stall_i=1 -> branch_taken_o=0, GHR unchanged. Same with mispredict_i=1, update_ghr=0x5A, real_taken=1, update_valid=1 -> GHR=0xB5 next cycle.
- update_valid_i and a predict to the same index in one cycle -> prediction uses the pre-update counter; the next cycle uses the updated counter.
